// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared FSM state encoding and index-width helper for
// layer_sequencer and its optional argmax_tracker.
package layer_seq_pkg;

  // Sequencer phases: gather a full frame, stream it out, then a one-cycle wrap-up.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2
  } seq_state_t;

  // Width of an index that addresses n slots. It is at least 1 bit, so the
  // degenerate single-neuron case still gives a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running signed maximum over the beats of one frame.
// This module is only instantiated by layer_sequencer when the macro
// LAYER_SEQ_ARGMAX_EN is defined.
// A beat at index 0 restarts the search. Only a strictly greater value
// replaces the current best, so on a tie the lower index is kept.
module argmax_tracker #(
  parameter int dataWidth = 16,
  parameter int IW        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat,
  input  logic                 last,
  input  logic [IW-1:0]        beat_idx,
  input  logic [dataWidth-1:0] beat_data,
  output logic [IW-1:0]        argmax_idx,
  output logic                 argmax_valid
);

  logic signed [dataWidth-1:0] max_val;
  logic [IW-1:0]               best_idx;
  logic                        take;
  logic [IW-1:0]               best_next;

  // Decide whether the current beat becomes the new best candidate.
  always_comb begin
    take      = (beat_idx == '0) || ($signed(beat_data) > max_val);
    best_next = take ? beat_idx : best_idx;
  end

  // Keep the running maximum, and publish the result on the final accepted beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val      <= '0;
      best_idx     <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= beat && last;
      if (beat) begin
        if (take) max_val <= $signed(beat_data);
        best_idx <= best_next;
        if (last) argmax_idx <= best_next;
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: gathers NN parallel neuron outputs and replays them as a
// ready/valid serial stream in index order, with a sticky overrun flag.
// Optional feature: define LAYER_SEQ_ARGMAX_EN to add the argmax_idx and
// argmax_valid outputs, which report the index of the largest word.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           l_valid,
  input  logic [NN*dataWidth-1:0] l_data,
  input  logic                    out_ready,
  output logic [dataWidth-1:0]    x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    layer_done,
  output logic                    overrun
`ifdef LAYER_SEQ_ARGMAX_EN
  ,
  output logic [idx_width(NN)-1:0] argmax_idx,
  output logic                     argmax_valid
`endif
);

  localparam int            IW       = idx_width(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  seq_state_t           state;
  logic [NN-1:0]        pending;
  logic [IW-1:0]        idx;
  logic [dataWidth-1:0] buffer [NN];
  logic [NN-1:0]        capture;
  logic [NN-1:0]        pending_next;
  logic                 accept;
  logic                 drop;

  // A slot captures only in COLLECT and only while it is still empty.
  for (genvar gi = 0; gi < NN; gi++) begin : g_capture
    assign capture[gi] = (state == COLLECT) && l_valid[gi] && !pending[gi];
  end

  // Derive the frame bookkeeping and the Moore outputs from the registered state.
  always_comb begin
    pending_next = pending | capture;
    accept       = (state == SHIFT) && out_ready;
    // Any valid pulse that was not captured is a dropped word.
    drop         = |(l_valid & ~capture);
    x_valid      = (state == SHIFT);
    x_out        = (state == SHIFT) ? buffer[idx] : '0;
    busy         = (state != COLLECT);
    layer_done   = (state == DONE);
  end

  // Frame storage. It needs no reset, because pending gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (capture[i]) buffer[i] <= l_data[i*dataWidth +: dataWidth];
    end
  end

  // Sequencer FSM: collect, stream with back-pressure, then pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= COLLECT;
      pending <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      case (state)
        COLLECT: begin
          pending <= pending_next;
          idx     <= '0;
          // Enter SHIFT together with the last capture, so x_valid rises in the next cycle.
          if (&pending_next) state <= SHIFT;
        end
        SHIFT: begin
          if (accept) begin
            if (idx == LAST_IDX) state <= DONE;
            else                 idx   <= idx + 1'b1;
          end
        end
        DONE: begin
          pending <= '0;
          idx     <= '0;
          state   <= COLLECT;
        end
        default: begin
          pending <= '0;
          idx     <= '0;
          state   <= COLLECT;
        end
      endcase
    end
  end

`ifdef LAYER_SEQ_ARGMAX_EN
  argmax_tracker #(
    .dataWidth (dataWidth),
    .IW        (IW)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .beat         (accept),
    .last         (idx == LAST_IDX),
    .beat_idx     (idx),
    .beat_data    (x_out),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scoreboard bench for layer_sequencer.
// Argmax checks are compiled in when LAYER_SEQ_ARGMAX_EN is defined.
module tb_layer_sequencer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NN-1:0]   l_valid = '0;
  logic [NN*DW-1:0] l_data = '0;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   x_out;
  logic            x_valid;
  logic            busy;
  logic            layer_done;
  logic            overrun;
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [3:0]      argmax_idx;
  logic            argmax_valid;
`endif

  layer_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .l_valid    (l_valid),
    .l_data     (l_data),
    .out_ready  (out_ready),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .busy       (busy),
    .layer_done (layer_done),
    .overrun    (overrun)
`ifdef LAYER_SEQ_ARGMAX_EN
    ,
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] words [NN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Score the beat visible in this cycle, then advance one clock.
  task automatic run_cycle();
    if (x_valid) begin
      if (exp_q.size() == 0) check("x_valid_spurious", x_valid, 0);
      else if (out_ready) check("x_out", x_out, exp_q.pop_front());
      else check("x_out_held", x_out, exp_q[0]);
    end
    tick();
  endtask

  // Run until layer_done, or until the cycle budget runs out. The ready pattern repeats every 4 cycles.
  task automatic drain(input logic [3:0] pat, input int bound, output int n);
    n = 0;
    while (!layer_done && n < bound) begin
      out_ready = pat[n % 4];
      run_cycle();
      n++;
    end
    out_ready = 1'b0;
    check("layer_done_seen", layer_done, 1);
  endtask

  task automatic send_all();
    for (int i = 0; i < NN; i++) begin
      l_data[i*DW +: DW] = words[i];
      exp_q.push_back(words[i]);
    end
    l_valid = '1;
    run_cycle();
    l_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst = 1'b0;
    tick(); tick();
    check("rst_x_valid", x_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_layer_done", layer_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_x_out", x_out, 0);
    rst = 1'b1;
    tick();

    // One-shot frame 0..9 with ready held high.
    for (int i = 0; i < NN; i++) words[i] = DW'(i);
    send_all();
    check("t1_busy", busy, 1);
    check("t1_x_valid", x_valid, 1);
    drain(4'b1111, 40, n);
    check("t1_len", n, 10);
    check("t1_done_busy", busy, 1);
    tick();
    check("t1_done_pulse", layer_done, 0);
    check("t1_idle", busy, 0);
    check("t1_queue", exp_q.size(), 0);

    // Skewed arrival: bit 9 first, bit 0 last, 3 cycles apart.
    for (int i = 0; i < NN; i++) begin
      words[i] = DW'(16'h0100 + i);
      exp_q.push_back(words[i]);
    end
    for (int b = NN - 1; b >= 0; b--) begin
      if (b == 0) check("t2_busy_before", busy, 0);
      l_data[b*DW +: DW] = words[b];
      l_valid = NN'(1) << b;
      run_cycle();
      l_valid = '0;
      if (b > 0) begin
        run_cycle();
        run_cycle();
      end
    end
    check("t2_shift_busy", busy, 1);
    check("t2_shift_valid", x_valid, 1);
    drain(4'b1111, 40, n);
    check("t2_len", n, 10);
    tick();
    check("t2_queue", exp_q.size(), 0);

    // Back-pressure: ready pattern 1,0,0,1.
    for (int i = 0; i < NN; i++) words[i] = DW'(16'h0200 + 3 * i);
    send_all();
    drain(4'b1001, 60, n);
    check("t3_len", n, 20);
    tick();
    check("t3_queue", exp_q.size(), 0);
    check("t3_overrun", overrun, 0);

    // Double pulse on bit 3 before the frame completes.
    do_reset();
    for (int i = 0; i < NN; i++) begin
      words[i] = DW'(16'h0300 + i);
      exp_q.push_back(words[i]);
    end
    l_data[3*DW +: DW] = words[3];
    l_valid = NN'(1) << 3;
    run_cycle();
    check("t4_first_ok", overrun, 0);
    l_data[3*DW +: DW] = 16'hDEAD;
    l_valid = NN'(1) << 3;
    run_cycle();
    check("t4_overrun", overrun, 1);
    check("t4_still_collect", busy, 0);
    for (int i = 0; i < NN; i++) if (i != 3) l_data[i*DW +: DW] = words[i];
    l_valid = ~(NN'(1) << 3);
    run_cycle();
    l_valid = '0;
    drain(4'b1111, 40, n);
    check("t4_len", n, 10);
    tick();
    check("t4_sticky", overrun, 1);
    check("t4_queue", exp_q.size(), 0);

    // A pulse on bit 3 during SHIFT is dropped and flags overrun.
    do_reset();
    check("t4b_rst_clear", overrun, 0);
    for (int i = 0; i < NN; i++) words[i] = DW'(16'h0400 + i);
    send_all();
    l_data[3*DW +: DW] = 16'hBEEF;
    l_valid = NN'(1) << 3;
    out_ready = 1'b1;
    run_cycle();
    l_valid = '0;
    check("t4b_overrun", overrun, 1);
    drain(4'b1111, 40, n);
    check("t4b_len", n, 9);
    tick();
    check("t4b_sticky", overrun, 1);
    check("t4b_queue", exp_q.size(), 0);

    // Reset at idx 5, then a fresh full frame.
    for (int i = 0; i < NN; i++) words[i] = DW'(16'h0500 + i);
    send_all();
    out_ready = 1'b1;
    repeat (5) run_cycle();
    check("t5_idx5", x_out, words[5]);
    rst = 1'b0;
    #1;
    check("t5_rst_x_valid", x_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_x_out", x_out, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_done", layer_done, 0);
    exp_q.delete();
    out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < NN; i++) words[i] = DW'(16'h0600 + i);
    send_all();
    drain(4'b1111, 40, n);
    check("t5_len", n, 10);
    tick();
    check("t5_idle", busy, 0);
    check("t5_queue", exp_q.size(), 0);

`ifdef LAYER_SEQ_ARGMAX_EN
    // Argmax with a tie: 7 appears at 1 and 3, so the lower index wins.
    do_reset();
    check("t6_rst_valid", argmax_valid, 0);
    words[0] = -16'sd3; words[1] = 16'sd7;  words[2] = 16'sd2;  words[3] = 16'sd7;
    words[4] = 16'sd0;  words[5] = 16'sd1;  words[6] = -16'sd5; words[7] = 16'sd3;
    words[8] = 16'sd4;  words[9] = -16'sd1;
    send_all();
    drain(4'b1111, 40, n);
    check("t6_valid_with_done", argmax_valid, 1);
    check("t6_idx", argmax_idx, 1);
    tick();
    check("t6_valid_pulse", argmax_valid, 0);
    check("t6_idx_hold", argmax_idx, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
